data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words (power of two, 16..4096).
REQ-002 SHALL have parameter RD_LAT, default 1, meaning cycles from read accept to read ack (1..4).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  request valid.
REQ-006 SHALL have port RW  input  1  1 = store, 0 = load.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port funct3  input  3  RV32I access size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 SHALL have port dataIN  input  32  store data, right-aligned.
REQ-010 SHALL have port dataOUT  output  32  load result, sign/zero-extended.
REQ-011 SHALL have port busy  output  1  request in flight; en ignored.
REQ-012 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  1  request rejected; valid only with ack.

Function
REQ-014 SHALL implement FSM states IDLE, RD_WAIT, ACK; busy = (state != IDLE).
REQ-015 SHALL accept a request at a rising edge where state=IDLE, en=1, rst=0; addr/funct3/dataIN/RW are sampled at that edge.
REQ-016 Store: SHALL update memory at the accept edge; FSM goes IDLE->ACK; ack=1 in the following cycle.
REQ-017 Load: SHALL go IDLE->RD_WAIT (RD_LAT>1) or IDLE->ACK (RD_LAT=1); ack and valid dataOUT exactly RD_LAT cycles after the accept edge, using a down-counter loaded with RD_LAT-1.
REQ-018 ACK SHALL last one cycle, then return to IDLE; the next request is accepted no earlier than the cycle after ack.
REQ-019 en asserted while busy=1 SHALL be ignored; there is no queuing.
REQ-020 SB SHALL write byte lane addr[1:0]; SH SHALL write lane addr[1]; SW SHALL write all four lanes; other lanes SHALL remain unchanged.
REQ-021 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend the addressed lane; LW SHALL return the full word.
REQ-022 err=1 SHALL be raised for any of: halfword with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= DEPTH; funct3 not legal for RW.
REQ-023 An erroneous request SHALL still be acked after its normal latency, SHALL NOT modify memory, and SHALL drive dataOUT=0.
REQ-024 dataOUT SHALL be 0 in every cycle except the ack cycle of a successful load.

Reset
REQ-025 rst SHALL force state=IDLE, counter=0, dataOUT=0, ack=0, busy=0, err=0 at the next edge.
REQ-026 rst SHALL take priority over en in the same cycle; that request is not accepted.
REQ-027 rst during RD_WAIT or ACK SHALL abort the request with no ack; a store already committed at its accept edge SHALL remain written.

Configuration
REQ-028 With MEM_CLR_EN defined, rst SHALL clear every memory word to 0 at the same edge.
REQ-029 Without MEM_CLR_EN, memory contents SHALL be retained across reset (no reset on the array).

Structure
REQ-030 A shared package SHALL hold the funct3 constants (LB..LHU, SB..SW) and the FSM state encoding.
REQ-031 Lane selection, store byte-enables and load extension SHALL live in a combinational sub-module lsu_align.

Verification
REQ-032 Reset, SW 0xDEADBEEF @0x10, then LW @0x10 -> store ack 1 cycle after accept; load ack RD_LAT cycles after accept; dataOUT=0xDEADBEEF, err=0.
REQ-033 SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-034 LW @0x12 -> ack with err=1, dataOUT=0; SH @0x11 -> err=1; a subsequent LW @0x10 returns the unchanged value.
REQ-035 en held high with alternating loads/stores -> accepts spaced RD_LAT+1 (load) / 2 (store) cycles apart; busy high between accepts; no extra acks.
REQ-036 rst one cycle after a load accept with RD_LAT=3 -> no ack; LW @0x10 afterwards returns 0 with MEM_CLR_EN and 0x80ADBEEF without.
REQ-037 LW at word index DEPTH (addr = 4*DEPTH) -> err=1, dataOUT=0; word index DEPTH-1 succeeds.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl_pkg
// Description : Shared RV32I funct3 codes, FSM states and request legality check
//               for the data memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_ACK     = 2'd2
    } state_e;

    // Illegal code for the direction, misalignment, or word index past the array.
    function automatic logic req_error(input logic        rw,
                                       input logic [2:0]  f3,
                                       input logic [31:0] a,
                                       input logic [31:0] depth);
        logic legal;
        if (rw) legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        else    legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                        (f3 == F3_LBU) || (f3 == F3_LHU);
        req_error = !legal ||
                    ((f3[1:0] == 2'b01) && a[0]) ||
                    ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00)) ||
                    ({2'b00, a[31:2]} >= depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_ctrl_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane selection, store byte-enables / replication
//               and load sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte   = rword_i[8*addr_lo_i +: 8];
        rhalf   = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        be_o    = 4'b0000;
        wword_o = 32'h0;
        rdata_o = 32'h0;

        // Store data is replicated so every enabled lane sees its own bits.
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wword_o = wdata_i;
            end
        endcase

        case (funct3_i)
            F3_LB:   rdata_o = {{24{rbyte[7]}}, rbyte};
            F3_LBU:  rdata_o = {24'h0, rbyte};
            F3_LH:   rdata_o = {{16{rhalf[15]}}, rhalf};
            F3_LHU:  rdata_o = {16'h0, rhalf};
            F3_LW:   rdata_o = rword_i;
            default: rdata_o = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Single-request RV32I data memory controller with configurable
//               read latency. Define MEM_CLR_EN to clear the array on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        RW,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] dataIN,
    output logic [31:0] dataOUT,
    output logic        busy,
    output logic        ack,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        ack_q;
    logic        err_q;
    logic [31:0] dout_q;
    logic [31:0] mem_q [DEPTH];

    logic          idle;
    logic [31:0]   req_addr;
    logic [2:0]    req_f3;
    logic          req_rw;
    logic          req_err;
    logic [AW-1:0] req_idx;
    logic [31:0]   rword;
    logic [3:0]    be;
    logic [31:0]   wword;
    logic [31:0]   rdata;
    logic          wr_en;

    // While idle the live inputs describe the request; afterwards the latched copy
    // does, so one aligner serves both the accept edge and the delayed ack edge.
    assign idle     = (state_q == S_IDLE);
    assign req_addr = idle ? addr : addr_q;
    assign req_f3   = idle ? funct3 : funct3_q;
    assign req_rw   = idle ? RW : 1'b0;
    assign req_err  = req_error(req_rw, req_f3, req_addr, 32'(DEPTH));
    assign req_idx  = req_addr[AW+1:2];
    assign rword    = mem_q[req_idx];
    assign wr_en    = idle && en && !rst && RW && !req_err;

    lsu_align u_align (
        .addr_lo_i (req_addr[1:0]),
        .funct3_i  (req_f3),
        .wdata_i   (dataIN),
        .rword_i   (rword),
        .be_o      (be),
        .wword_o   (wword),
        .rdata_o   (rdata)
    );

    always_ff @(posedge clk) begin
`ifdef MEM_CLR_EN
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
        end else if (wr_en) begin
`else
        if (wr_en) begin
`endif
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[req_idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            addr_q   <= 32'h0;
            funct3_q <= 3'd0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dout_q   <= 32'h0;
        end else begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            dout_q <= 32'h0;
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        addr_q   <= addr;
                        funct3_q <= funct3;
                        if (RW || (RD_LAT == 1)) begin
                            state_q <= S_ACK;
                            ack_q   <= 1'b1;
                            err_q   <= req_err;
                            dout_q  <= (!RW && !req_err) ? rdata : 32'h0;
                        end else begin
                            state_q <= S_RD_WAIT;
                            cnt_q   <= 3'(RD_LAT - 1);
                        end
                    end
                end
                S_RD_WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                        err_q   <= req_err;
                        dout_q  <= req_err ? 32'h0 : rdata;
                    end
                end
                S_ACK:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = !idle;
    assign ack     = ack_q;
    assign err     = err_q;
    assign dataOUT = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Randomized self-checking bench for data_mem_ctrl against a
//               byte-array reference model. Honours MEM_CLR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;
    localparam int DEPTH  = 64;
    localparam int RD_LAT = 3;

    logic        clk = 1'b0;
    logic        rst, en, RW;
    logic [31:0] addr, dataIN, dataOUT;
    logic [2:0]  funct3;
    logic        busy, ack, err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] mem_m [4*DEPTH];

    data_mem_ctrl #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .en(en), .RW(RW), .addr(addr), .funct3(funct3),
        .dataIN(dataIN), .dataOUT(dataOUT), .busy(busy), .ack(ack), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_err(input bit rw, input bit [2:0] f3, input bit [31:0] a);
        bit legal;
        int sz;
        if (rw) legal = (f3 <= 2);
        else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        if (!legal) return 1'b1;
        sz = 1 << f3[1:0];
        if ((a % sz) != 0) return 1'b1;
        if ((a / 4) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input bit [2:0] f3, input bit [31:0] a);
        int i;
        i = int'(a);
        case (f3)
            3'd0:    return {{24{mem_m[i][7]}}, mem_m[i]};
            3'd4:    return {24'h0, mem_m[i]};
            3'd1:    return {{16{mem_m[i+1][7]}}, mem_m[i+1], mem_m[i]};
            3'd5:    return {16'h0, mem_m[i+1], mem_m[i]};
            default: return {mem_m[i+3], mem_m[i+2], mem_m[i+1], mem_m[i]};
        endcase
    endfunction

    task automatic m_store(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] d);
        for (int i = 0; i < (1 << f3[1:0]); i++) mem_m[int'(a) + i] = d[8*i +: 8];
    endtask

    task automatic m_reset();
`ifdef MEM_CLR_EN
        for (int i = 0; i < 4*DEPTH; i++) mem_m[i] = 8'h00;
`endif
    endtask

    // Called at a negedge with the DUT idle; returns at the next idle negedge.
    task automatic do_req(input bit rw, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] d, input bit hold, output logic [31:0] rd);
        bit e;
        logic [31:0] exp_d, got_d;
        logic got_e;
        int k, nack, lat, nbusy, stray;
        e     = m_err(rw, f3, a);
        exp_d = (!rw && !e) ? m_load(f3, a) : 32'h0;
        check_eq("idle_before_req", {31'h0, busy}, 32'h0);
        en = 1'b1; RW = rw; funct3 = f3; addr = a; dataIN = d;
        @(posedge clk);
        if (rw && !e) m_store(f3, a, d);
        k = 0; nack = 0; lat = 0; nbusy = 0; stray = 0;
        got_d = 'x; got_e = 1'bx;
        do begin
            @(negedge clk);
            k++;
            if (!hold) en = 1'b0;
            if (ack) begin
                nack++; lat = k; got_e = err; got_d = dataOUT;
            end else if (err || (dataOUT != 32'h0)) begin
                stray++;
            end
            if (busy) nbusy++;
        end while (busy && k < 20);
        check_eq("ack_count", nack, 1);
        check_eq("ack_latency", lat, rw ? 1 : RD_LAT);
        check_eq("busy_span", nbusy, rw ? 1 : RD_LAT);
        check_eq("err", {31'h0, got_e}, {31'h0, e});
        check_eq("dataOUT", got_d, exp_d);
        check_eq("quiet_outputs", stray, 0);
        rd = got_d;
    endtask

    initial begin
        logic [31:0] rd;
        int nack;
        rst = 1'b1; en = 1'b0; RW = 1'b0; addr = 32'h0; funct3 = 3'd0; dataIN = 32'h0;
        m_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_ack", {31'h0, ack}, 32'h0);
        check_eq("rst_err", {31'h0, err}, 32'h0);
        check_eq("rst_dataOUT", dataOUT, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int w = 0; w < DEPTH; w++) do_req(1'b1, 3'd2, 32'(4*w), $urandom, 1'b0, rd);

        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, rd);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, rd);
        check_eq("lw_deadbeef", rd, 32'hDEADBEEF);
        do_req(1'b1, 3'd0, 32'h13, 32'h00000080, 1'b0, rd);
        do_req(1'b0, 3'd0, 32'h13, 32'h0, 1'b0, rd);
        check_eq("lb_sext", rd, 32'hFFFFFF80);
        do_req(1'b0, 3'd4, 32'h13, 32'h0, 1'b0, rd);
        check_eq("lbu_zext", rd, 32'h00000080);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, rd);
        check_eq("lw_after_sb", rd, 32'h80ADBEEF);
        do_req(1'b0, 3'd2, 32'h12, 32'h0, 1'b0, rd);
        do_req(1'b1, 3'd1, 32'h11, 32'h5555, 1'b0, rd);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, rd);
        check_eq("lw_after_err", rd, 32'h80ADBEEF);

        // Back-to-back with en held: spacing is enforced by busy_span/ack_latency.
        for (int i = 0; i < 6; i++)
            do_req(i[0], (i % 3 == 0) ? 3'd2 : 3'd0, 32'(8'h40 + 4*(i/2)), $urandom, 1'b1, rd);
        en = 1'b0;

        do_req(1'b0, 3'd2, 32'(4*DEPTH), 32'h0, 1'b0, rd);
        do_req(1'b0, 3'd2, 32'(4*(DEPTH-1)), 32'h0, 1'b0, rd);

        // Reset one cycle after a load accept aborts it silently.
        en = 1'b1; RW = 1'b0; funct3 = 3'd2; addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) nack++;
        end
        check_eq("abort_no_ack", nack, 0);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, rd);
`ifdef MEM_CLR_EN
        check_eq("lw_after_rst", rd, 32'h0);
`else
        check_eq("lw_after_rst", rd, 32'h80ADBEEF);
`endif

        // Reset beats en in the same cycle: the store must not land.
        rst = 1'b1; en = 1'b1; RW = 1'b1; funct3 = 3'd2; addr = 32'h20; dataIN = 32'h12345678;
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        m_reset();
        @(negedge clk);
        check_eq("rst_prio_busy", {31'h0, busy}, 32'h0);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, rd);

        // Reset in the store's ack cycle keeps the committed write.
        en = 1'b1; RW = 1'b1; funct3 = 3'd2; addr = 32'h24; dataIN = 32'hCAFEF00D;
        @(posedge clk);
        m_store(3'd2, 32'h24, 32'hCAFEF00D);
        @(negedge clk);
        en = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        do_req(1'b0, 3'd2, 32'h24, 32'h0, 1'b0, rd);

        for (int n = 0; n < 80; n++) begin
            bit [31:0] a;
            bit [2:0]  f3;
            bit        rw;
            rw = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, DEPTH + 1) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (rw)                   f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_req(rw, f3, a, $urandom, 1'($urandom_range(0, 1)), rd);
        end
        en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
